sigmf_bwd: RTL and testbench



---
 rtl/dnn_fixed_pkg.sv | 25 ++
 rtl/sigmf_bwd_mul.sv | 34 +++
 rtl/sigmf_bwd.sv | 90 +++++++++
 tb/tb_sigmf_bwd.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/dnn_fixed_pkg.sv
// Shared Q8.24 fixed-point constants and FSM state type for the LSTM backward path.
// SIGMF_BWD_SAT_EN selects saturating (defined) or wrapping (undefined) multiplies.
package dnn_fixed_pkg;

  localparam int WIDTH = 32;
  localparam int FRAC  = 24;

  localparam logic [WIDTH-1:0] ONE = 32'h0100_0000;
  localparam logic [WIDTH-1:0] MAX = 32'h7FFF_FFFF;
  localparam logic [WIDTH-1:0] MIN = 32'h8000_0000;

`ifdef SIGMF_BWD_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    MUL1,
    MUL2,
    DONE
  } state_t;

endpackage

// File: rtl/sigmf_bwd_mul.sv
// Combinational signed fixed-point multiply with floor shift.
// Saturates out-of-range products when SIGMF_BWD_SAT_EN is defined, else wraps.
module sigmf_bwd_mul
  import dnn_fixed_pkg::*;
#(
  parameter int WIDTH = dnn_fixed_pkg::WIDTH,
  parameter int FRAC  = dnn_fixed_pkg::FRAC
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic        [WIDTH-1:0] p,
  output logic                    sat
);

  localparam logic [WIDTH-1:0] HI_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] LO_V = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] full;
  logic signed [2*WIDTH-1:0] shr;
  logic [WIDTH:0]            top;
  logic                      ovf;

  always_comb begin
    full = a * b;
    shr  = full >>> FRAC;
    // fits in WIDTH bits only if all bits from the sign position up agree
    top  = shr[2*WIDTH-1:WIDTH-1];
    ovf  = ~((&top) | ~(|top));
    sat  = SAT_EN & ovf;
    p    = shr[WIDTH-1:0];
    if (sat) p = shr[2*WIDTH-1] ? LO_V : HI_V;
  end

endmodule

// File: rtl/sigmf_bwd.sv
// Sigmoid backward gradient: delta = e * y * (1 - y), Q8.24, one shared multiplier.
// Saturation and the sticky o_sat flag exist only under SIGMF_BWD_SAT_EN.
module sigmf_bwd
  import dnn_fixed_pkg::*;
#(
  parameter int WIDTH = dnn_fixed_pkg::WIDTH,
  parameter int FRAC  = dnn_fixed_pkg::FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_err,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_delta,
  output logic             o_sat
);

  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1) << FRAC;

  state_t state, state_nx;

  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] err_r;
  logic [WIDTH-1:0] t_r;
  logic [WIDTH-1:0] m_a;
  logic [WIDTH-1:0] m_b;
  logic [WIDTH-1:0] m_p;
  logic             m_sat;
  logic             accept;
  logic             sat_r;

  assign i_ready = (state == IDLE) | ((state == DONE) & o_ready);
  assign o_valid = (state == DONE);
  assign accept  = i_valid & i_ready;
  assign o_sat   = sat_r;

  always_comb begin
    m_a = t_r;
    m_b = err_r;
    if (state == MUL1) begin
      m_a = y_r;
      m_b = ONE_V - y_r;
    end
  end

  sigmf_bwd_mul #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_mul (
    .a   (m_a),
    .b   (m_b),
    .p   (m_p),
    .sat (m_sat)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (i_valid) state_nx = MUL1;
      MUL1: state_nx = MUL2;
      MUL2: state_nx = DONE;
      DONE: if (o_ready) state_nx = i_valid ? MUL1 : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      y_r     <= '0;
      err_r   <= '0;
      t_r     <= '0;
      o_delta <= '0;
      sat_r   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        y_r   <= i_y;
        err_r <= i_err;
      end
      if (state == MUL1) t_r <= m_p;
      if (state == MUL2) o_delta <= m_p;
      if (((state == MUL1) | (state == MUL2)) & m_sat) sat_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sigmf_bwd.sv
// Directed self-checking bench for sigmf_bwd.
// Expected saturation results follow SIGMF_BWD_SAT_EN.
module tb_sigmf_bwd;
  import dnn_fixed_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_y;
  logic [31:0] i_err;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_delta;
  logic        o_sat;

  int n_asserts = 0;
  int n_fail    = 0;

  sigmf_bwd dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_y     (i_y),
    .i_err   (i_err),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_delta (o_delta),
    .o_sat   (o_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // entered just after a rising edge; o_ready held high
  task automatic run(input string tag, input logic [31:0] y,
                     input logic [31:0] e, input logic [31:0] exp);
    i_y = y;
    i_err = e;
    i_valid = 1'b1;
    o_ready = 1'b1;
    #1 chk({tag, ".i_ready"}, 32'(i_ready), 32'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk({tag, ".v_e0"}, 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".v_e1"}, 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".v_e2"}, 32'(o_valid), 32'd1);
    chk({tag, ".delta"}, o_delta, exp);
    @(posedge clk); #1;
    chk({tag, ".v_e3"}, 32'(o_valid), 32'd0);
  endtask

  logic [31:0] held;

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b0;
    i_y     = '0;
    i_err   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst.i_ready", 32'(i_ready), 32'd1);
    chk("rst.o_valid", 32'(o_valid), 32'd0);
    chk("rst.o_delta", o_delta, 32'h0000_0000);
    chk("rst.o_sat", 32'(o_sat), 32'd0);

    run("nominal", 32'h0080_0000, ONE, 32'h0040_0000);
    run("neg_err", 32'h0080_0000, 32'hFE00_0000, 32'hFF80_0000);
    run("y_zero", 32'h0000_0000, 32'h1234_5678, 32'h0000_0000);
    run("y_one", ONE, 32'h0300_0000, 32'h0000_0000);
    // -0.25 lsb floors to -1 lsb
    run("floor", 32'h0080_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("tiny_y", 32'h0000_0001, ONE, 32'h0000_0000);
    chk("nosat.o_sat", 32'(o_sat), 32'd0);

    // backpressure then back-to-back accept on the retiring edge
    i_y = 32'h0080_0000;
    i_err = ONE;
    i_valid = 1'b1;
    o_ready = 1'b0;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("bp.valid", 32'(o_valid), 32'd1);
    chk("bp.delta", o_delta, 32'h0040_0000);
    chk("bp.i_ready", 32'(i_ready), 32'd0);
    held = o_delta;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp.hold_v%0d", k), 32'(o_valid), 32'd1);
      chk($sformatf("bp.hold_d%0d", k), o_delta, held);
      chk($sformatf("bp.hold_r%0d", k), 32'(i_ready), 32'd0);
    end
    o_ready = 1'b1;
    i_valid = 1'b1;
    i_y = 32'h0080_0000;
    i_err = 32'hFE00_0000;
    #1 chk("b2b.i_ready", 32'(i_ready), 32'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("b2b.retire", 32'(o_valid), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    chk("b2b.valid", 32'(o_valid), 32'd1);
    chk("b2b.delta", o_delta, 32'hFF80_0000);
    @(posedge clk); #1;
    chk("b2b.drop", 32'(o_valid), 32'd0);

`ifdef SIGMF_BWD_SAT_EN
    run("sat", 32'hC000_0000, ONE, 32'h8000_0000);
    chk("sat.o_sat", 32'(o_sat), 32'd1);
`else
    run("wrap", 32'hC000_0000, ONE, 32'hC000_0000);
    chk("wrap.o_sat", 32'(o_sat), 32'd0);
`endif

    // reset while in MUL2
    i_y = 32'h0080_0000;
    i_err = ONE;
    i_valid = 1'b1;
    o_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid.o_valid", 32'(o_valid), 32'd0);
    chk("mid.o_delta", o_delta, 32'h0000_0000);
    chk("mid.o_sat", 32'(o_sat), 32'd0);
    chk("mid.i_ready", 32'(i_ready), 32'd1);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("mid.after_v%0d", k), 32'(o_valid), 32'd0);
    end
    run("fresh", 32'h0080_0000, 32'hFE00_0000, 32'hFF80_0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule
